vec_hazard_scoreboard: RTL and testbench
========================================

Name: vec_hazard_scoreboard

Overview:
- Pipeline controller that sequences the vector register file read ports in the decode stage.
- Tracks in-flight vector writes in the E, M and W stages.
- Generates the decode stall, per-operand forwarding selects and a pipeline-drain handshake.
- Sits beside the decode stage and drives the control inputs of the hazard/forward muxes in execute.

Parameters:
- NREG, 16, number of vector registers (address width is clog2(NREG)).
- AW, 4, register address width.
- PC_REG, 15, register address never tracked; reads of it never stall or forward.
- SCW, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- issue_valid  input  1  decode holds a valid instruction.
- issue_we  input  1  the issuing instruction writes a vector register.
- issue_ld  input  1  the issuing instruction is a load (result available only in W).
- issue_wa  input  AW  destination register of the issuing instruction.
- ra1, ra2  input  AW  decode read addresses (post RegSrc mux).
- use1, use2  input  1  the corresponding read operand is actually consumed.
- wb_valid  input  1  RegWriteW from writeback.
- wb_wa  input  AW  wa3w from writeback.
- drain_req  input  1  request to empty the pipeline (mode switch, flush).
- stall_d  output  1  hold decode/fetch and insert a bubble into E.
- fwd1, fwd2  output  2  operand select: 00 regfile, 10 from M, 01 from W.
- busy  output  NREG  bit set while any slot targets that register.
- drain_done  output  1  one-cycle pulse when the drain completes.
- wb_mismatch  output  1  sticky error flag.
- stall_cnt  output  SCW  saturating count of stall cycles.

Behaviour:
- Three slots E, M, W, each holding {v, ld, wa}.
- Reset (async): all slots v=0; state=RUN; stall_cnt=0; wb_mismatch=0.
- Reset output values: stall_d=0, fwd=00, busy=0, drain_done=0.
- Every clock edge: W<=M, M<=E.
- E loads {issue_valid&issue_we&(issue_wa!=PC_REG), issue_ld, issue_wa} when accepted; otherwise E.v<=0 (bubble).
- Accepted means issue_valid & !stall_d & state==RUN.
- Hazard check for operand k (combinational, same cycle), with ra=rak and use=usek. Priority is youngest first:
  - use=0 or ra==PC_REG: no hazard, fwd=00.
  - E.v & E.wa==ra: stall (result not yet computed).
  - else M.v & M.wa==ra & M.ld: stall.
  - else M.v & M.wa==ra: fwd=10.
  - else W.v & W.wa==ra: fwd=01.
  - else fwd=00.
- stall_d = issue_valid & (hazard on either operand | state!=RUN).
- fwd outputs are valid only when stall_d=0.
- busy[r] = OR over slots of (v & wa==r). busy is combinational from the slot registers.
- Writeback check: each cycle, compare wb_valid/wb_wa against W.v/W.wa as they stood before the edge. Any difference sets wb_mismatch, which stays set until RST.
- stall_cnt increments on every cycle with stall_d=1 and saturates at all-ones.
- Drain FSM:
  - RUN: drain_req=1 -> DRAIN. While in DRAIN, no new issue is accepted.
  - DRAIN: when E.v|M.v|W.v == 0 -> DONE.
  - DONE: drain_done=1 for exactly one cycle, then -> RUN.
  - drain_req held high in DONE does not re-enter DRAIN until it has been seen low for one cycle.
- Drain latency is at most 3 cycles plus 1 cycle for the pulse. If the pipeline is already empty, DRAIN lasts exactly 1 cycle.
- Simultaneous events:
  - A stall and drain_req in the same cycle: drain wins, and the bubble is inserted.
  - Issue writing a register that is also being read in the same instruction (e.g. Vr3 <- Vr3 op Vr3): the check uses the older slots only, never the instruction's own destination.
- Reset asserted mid-drain: the FSM returns to RUN and all slots are cleared immediately. No drain_done is produced.

Decomposition:
- Shared package vec_ctrl_pkg holds:
  - typedef slot_t {v, ld, wa[AW-1:0]};
  - enum drain_state_t {RUN, DRAIN, DONE};
  - localparams FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
- One natural sub-module: vec_operand_hazard. It is instantiated twice, and holds the per-operand priority compare that produces {stall, fwd}.

Test Plan:
- Back-to-back dependency: issue write Vr3 (ALU), next cycle read ra1=3 -> stall_d=1 for 1 cycle, then fwd1=10; stall_cnt=1.
- Load-use: issue load Vr5, next cycle read ra2=5 -> stall_d=1 for 2 cycles, then fwd2=01; busy[5]=1 for 3 cycles.
- Two-apart ALU dependency: write Vr7, unrelated instruction, read ra1=7 -> no stall, fwd1=10. With two unrelated instructions in between -> fwd1=01.
- PC/unused operands: ra1=15, or use2=0 with ra2 matching E.wa -> stall_d=0, fwd=00.
- Drain: three writes in flight, pulse drain_req -> stall_d=1 with issue_valid held, drain_done pulses exactly 4 cycles later, busy==0 at the pulse. Assert RST during DRAIN in a second run -> no pulse, all slots cleared.
- Writeback mismatch: drive wb_valid=1, wb_wa=2 while W holds wa=4 -> wb_mismatch=1 and stays 1 until RST.

Source files
------------

// File: rtl/vec_ctrl_pkg.sv
// Shared types and constants for the vector hazard scoreboard: the pipeline
// slot record, the drain FSM state encoding and the forwarding select codes.
package vec_ctrl_pkg;

    localparam int VEC_AW   = 4;
    localparam int VEC_NREG = 16;
    localparam int VEC_SCW  = 16;

    // One in-flight vector write: valid, is-a-load, destination register.
    typedef struct packed {
        logic              v;
        logic              ld;
        logic [VEC_AW-1:0] wa;
    } slot_t;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        DRAIN = 2'b01,
        DONE  = 2'b10
    } drain_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // True when a slot holds a live write to register ra.
    function automatic logic slot_hit(input slot_t s, input logic [VEC_AW-1:0] ra);
        return s.v && (s.wa == ra);
    endfunction

endpackage

// File: rtl/vec_hazard_scoreboard_if.sv
// Decode-side bundle of the hazard scoreboard: issue request, read operands,
// writeback echo, drain handshake and the stall/forward/status results.
interface vec_hazard_scoreboard_if #(
    parameter int AW   = 4,
    parameter int NREG = 16,
    parameter int SCW  = 16
);
    logic            issue_valid;
    logic            issue_we;
    logic            issue_ld;
    logic [AW-1:0]   issue_wa;
    logic [AW-1:0]   ra1;
    logic [AW-1:0]   ra2;
    logic            use1;
    logic            use2;
    logic            wb_valid;
    logic [AW-1:0]   wb_wa;
    logic            drain_req;
    logic            stall_d;
    logic [1:0]      fwd1;
    logic [1:0]      fwd2;
    logic [NREG-1:0] busy;
    logic            drain_done;
    logic            wb_mismatch;
    logic [SCW-1:0]  stall_cnt;

    // Decode stage / environment side.
    modport master (
        output issue_valid, issue_we, issue_ld, issue_wa,
        output ra1, ra2, use1, use2, wb_valid, wb_wa, drain_req,
        input  stall_d, fwd1, fwd2, busy, drain_done, wb_mismatch, stall_cnt
    );

    // Scoreboard side.
    modport slave (
        input  issue_valid, issue_we, issue_ld, issue_wa,
        input  ra1, ra2, use1, use2, wb_valid, wb_wa, drain_req,
        output stall_d, fwd1, fwd2, busy, drain_done, wb_mismatch, stall_cnt
    );
endinterface

// File: rtl/vec_operand_hazard.sv
// Per-operand hazard resolver: walks the E, M, W slots youngest first and
// decides whether the operand must stall or where it should be forwarded from.
module vec_operand_hazard
    import vec_ctrl_pkg::*;
#(
    parameter logic [VEC_AW-1:0] PC_REG = 4'd15
) (
    input  logic [VEC_AW-1:0] i_ra,
    input  logic              i_use,
    input  slot_t             i_e,
    input  slot_t             i_m,
    input  slot_t             i_w,
    output logic              o_stall,
    output logic [1:0]        o_fwd
);

    // Youngest matching producer wins; E is never ready, a load in M is not ready yet.
    always_comb begin
        o_stall = 1'b0;
        o_fwd   = FWD_RF;
        if (!i_use || (i_ra == PC_REG)) begin
            o_stall = 1'b0;
            o_fwd   = FWD_RF;
        end else if (slot_hit(i_e, i_ra)) begin
            o_stall = 1'b1;
        end else if (slot_hit(i_m, i_ra) && i_m.ld) begin
            o_stall = 1'b1;
        end else if (slot_hit(i_m, i_ra)) begin
            o_fwd = FWD_M;
        end else if (slot_hit(i_w, i_ra)) begin
            o_fwd = FWD_W;
        end else begin
            o_fwd = FWD_RF;
        end
    end

endmodule

// File: rtl/vec_hazard_scoreboard.sv
// Decode-stage hazard scoreboard for the vector register file. Tracks writes
// in flight through E/M/W, stalls decode on unresolved RAW hazards, selects
// forwarding paths, cross-checks writeback and runs the pipeline-drain handshake.
module vec_hazard_scoreboard
    import vec_ctrl_pkg::*;
#(
    parameter int              NREG   = VEC_NREG,
    parameter int              AW     = VEC_AW,
    parameter logic [AW-1:0]   PC_REG = 4'd15,
    parameter int              SCW    = VEC_SCW
) (
    input  logic                  clk,
    input  logic                  RST,
    vec_hazard_scoreboard_if.slave bus
);

    slot_t          r_e;
    slot_t          r_m;
    slot_t          r_w;
    slot_t          w_e_nxt;
    drain_state_t   r_state;
    drain_state_t   w_state_nxt;
    logic           r_armed;
    logic           w_armed_nxt;
    logic           r_wb_mismatch;
    logic [SCW-1:0] r_stall_cnt;

    logic           w_stall1;
    logic           w_stall2;
    logic [1:0]     w_fwd1;
    logic [1:0]     w_fwd2;
    logic           w_stall_d;
    logic           w_accept;
    logic           w_pipe_empty;
    logic           w_wb_diff;
    logic [NREG-1:0] w_busy;

    vec_operand_hazard #(.PC_REG(PC_REG)) u_haz1 (
        .i_ra    (bus.ra1),
        .i_use   (bus.use1),
        .i_e     (r_e),
        .i_m     (r_m),
        .i_w     (r_w),
        .o_stall (w_stall1),
        .o_fwd   (w_fwd1)
    );

    vec_operand_hazard #(.PC_REG(PC_REG)) u_haz2 (
        .i_ra    (bus.ra2),
        .i_use   (bus.use2),
        .i_e     (r_e),
        .i_m     (r_m),
        .i_w     (r_w),
        .o_stall (w_stall2),
        .o_fwd   (w_fwd2)
    );

    assign w_stall_d    = bus.issue_valid & (w_stall1 | w_stall2 | (r_state != RUN));
    assign w_accept     = bus.issue_valid & ~w_stall_d & (r_state == RUN);
    assign w_pipe_empty = ~(r_e.v | r_m.v | r_w.v);
    // Writeback must echo exactly what W held; the address only matters when both are valid.
    assign w_wb_diff    = (bus.wb_valid != r_w.v) |
                          (bus.wb_valid & r_w.v & (bus.wb_wa != r_w.wa));

    // Next E slot: the accepted instruction's write (never to the PC register), else a bubble.
    always_comb begin
        w_e_nxt = '0;
        if (w_accept) begin
            w_e_nxt.v  = bus.issue_we & (bus.issue_wa != PC_REG);
            w_e_nxt.ld = bus.issue_ld;
            w_e_nxt.wa = bus.issue_wa;
        end else begin
            w_e_nxt = '0;
        end
    end

    // Advance the E -> M -> W slot pipeline every cycle.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_e <= '0;
            r_m <= '0;
            r_w <= '0;
        end else begin
            r_e <= w_e_nxt;
            r_m <= r_e;
            r_w <= r_m;
        end
    end

    // Drain FSM next state; re-arming requires drain_req to be seen low once.
    always_comb begin
        w_state_nxt = r_state;
        w_armed_nxt = r_armed;
        case (r_state)
            RUN: begin
                if (bus.drain_req && r_armed) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DRAIN: begin
                if (w_pipe_empty) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            DONE: begin
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
        if (!bus.drain_req) begin
            w_armed_nxt = 1'b1;
        end else if ((r_state == RUN) && r_armed) begin
            w_armed_nxt = 1'b0;
        end else begin
            w_armed_nxt = r_armed;
        end
    end

    // Drain FSM state and arm flag registers.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state <= RUN;
            r_armed <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_armed <= w_armed_nxt;
        end
    end

    // Sticky writeback-mismatch flag and saturating stall-cycle counter.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_wb_mismatch <= 1'b0;
            r_stall_cnt   <= '0;
        end else begin
            r_wb_mismatch <= r_wb_mismatch | w_wb_diff;
            if (w_stall_d && (r_stall_cnt != {SCW{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + SCW'(1);
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
        end
    end

    // Per-register busy map straight from the slot registers.
    always_comb begin
        w_busy = '0;
        for (int r = 0; r < NREG; r++) begin
            w_busy[r] = slot_hit(r_e, r[AW-1:0]) |
                        slot_hit(r_m, r[AW-1:0]) |
                        slot_hit(r_w, r[AW-1:0]);
        end
    end

    assign bus.stall_d     = w_stall_d;
    assign bus.fwd1        = w_fwd1;
    assign bus.fwd2        = w_fwd2;
    assign bus.busy        = w_busy;
    assign bus.drain_done  = (r_state == DONE);
    assign bus.wb_mismatch = r_wb_mismatch;
    assign bus.stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_vec_hazard_scoreboard.sv
// Scoreboard bench for vec_hazard_scoreboard: a stimulus process drives each
// cycle and pushes the reference model's expected outputs; a monitor on the
// falling edge pops and compares.
module tb_vec_hazard_scoreboard;

    logic clk = 1'b0;
    logic RST;
    always #5 clk = ~clk;

    vec_hazard_scoreboard_if vif ();
    vec_hazard_scoreboard dut (.clk(clk), .RST(RST), .bus(vif));

    typedef struct {
        logic        stall;
        logic [1:0]  f1;
        logic [1:0]  f2;
        logic [15:0] busy;
        logic        done;
        logic        mism;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: in-flight writes indexed by age (0 = just issued).
    bit   pv[3];
    bit   pld[3];
    int   pwa[3];
    int   mode;      // 0 running, 1 draining, 2 drain complete
    bit   armed;
    bit   mism;
    int   cnt;
    bit   wb_force;

    function automatic void model_reset();
        for (int a = 0; a < 3; a++) begin
            pv[a] = 0; pld[a] = 0; pwa[a] = 0;
        end
        mode = 0; armed = 1; mism = 0; cnt = 0;
    endfunction

    // A result is usable once it is at least 1 stage old (ALU) or 2 stages old (load).
    function automatic void chk_op(input int ra, input bit use_op, output bit st, output logic [1:0] f);
        st = 0; f = 2'b00;
        if (!use_op || ra == 15) return;
        for (int age = 0; age < 3; age++) begin
            if (pv[age] && pwa[age] == ra) begin
                if (age < (pld[age] ? 2 : 1)) st = 1;
                else f = (age == 1) ? 2'b10 : 2'b01;
                return;
            end
        end
    endfunction

    task automatic step();
        exp_t e;
        bit s1, s2, stall, acc, empty, narmed;
        logic [1:0] f1, f2;
        int nmode;
        if (RST) model_reset();
        if (!wb_force) begin
            vif.wb_valid = pv[2];
            vif.wb_wa    = pv[2] ? 4'(pwa[2]) : 4'($urandom_range(0, 15));
        end
        chk_op(int'(vif.ra1), vif.use1, s1, f1);
        chk_op(int'(vif.ra2), vif.use2, s2, f2);
        stall  = vif.issue_valid && (s1 || s2 || mode != 0);
        e.stall = stall; e.f1 = f1; e.f2 = f2;
        e.busy = 16'h0000;
        for (int a = 0; a < 3; a++) if (pv[a]) e.busy[pwa[a]] = 1'b1;
        e.done = (mode == 2);
        e.mism = mism;
        e.cnt  = 16'(cnt);
        q.push_back(e);
        if (!RST) begin
            acc = vif.issue_valid && !stall && mode == 0;
            if (vif.wb_valid != pv[2] || (vif.wb_valid && pv[2] && int'(vif.wb_wa) != pwa[2])) mism = 1;
            if (stall && cnt < 65535) cnt++;
            empty = !(pv[0] || pv[1] || pv[2]);
            nmode = mode; narmed = armed;
            if (mode == 0 && vif.drain_req && armed) nmode = 1;
            if (mode == 1 && empty) nmode = 2;
            if (mode == 2) nmode = 0;
            if (!vif.drain_req) narmed = 1;
            else if (mode == 0 && armed) narmed = 0;
            mode = nmode; armed = narmed;
            for (int a = 2; a > 0; a--) begin
                pv[a] = pv[a-1]; pld[a] = pld[a-1]; pwa[a] = pwa[a-1];
            end
            pv[0]  = acc && vif.issue_we && int'(vif.issue_wa) != 15;
            pld[0] = vif.issue_ld;
            pwa[0] = int'(vif.issue_wa);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit iv, input bit we, input bit ld, input int wa,
                          input int r1, input bit u1, input int r2, input bit u2, input bit dr);
        vif.issue_valid = iv; vif.issue_we = we; vif.issue_ld = ld; vif.issue_wa = 4'(wa);
        vif.ra1 = 4'(r1); vif.use1 = u1; vif.ra2 = 4'(r2); vif.use2 = u2; vif.drain_req = dr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
            step();
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: compare the DUT against the oldest queued expectation on each falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            cmp("stall_d", 32'(vif.stall_d), 32'(e.stall));
            if (!e.stall) begin
                cmp("fwd1", 32'(vif.fwd1), 32'(e.f1));
                cmp("fwd2", 32'(vif.fwd2), 32'(e.f2));
            end
            cmp("busy", 32'(vif.busy), 32'(e.busy));
            cmp("drain_done", 32'(vif.drain_done), 32'(e.done));
            cmp("wb_mismatch", 32'(vif.wb_mismatch), 32'(e.mism));
            cmp("stall_cnt", 32'(vif.stall_cnt), 32'(e.cnt));
        end
    end

    initial begin
        wb_force = 0;
        model_reset();
        RST = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        vif.wb_valid = 1'b0; vif.wb_wa = 4'd0;
        @(posedge clk); #1;
        step();
        RST = 1'b0;
        idle(2);

        // Back-to-back ALU dependency on Vr3.
        set_in(1, 1, 0, 3, 0, 0, 0, 0, 0); step();
        set_in(1, 0, 0, 0, 3, 1, 9, 0, 0); step(); step();
        idle(3);

        // Load-use on Vr5 through operand 2.
        set_in(1, 1, 1, 5, 0, 0, 0, 0, 0); step();
        set_in(1, 0, 0, 0, 1, 0, 5, 1, 0); step(); step(); step();
        idle(3);

        // One and two unrelated instructions between producer and consumer.
        set_in(1, 1, 0, 7, 0, 0, 0, 0, 0); step();
        set_in(1, 0, 0, 0, 1, 0, 2, 0, 0); step();
        set_in(1, 0, 0, 0, 7, 1, 0, 0, 0); step();
        idle(3);
        set_in(1, 1, 0, 7, 0, 0, 0, 0, 0); step();
        set_in(1, 0, 0, 0, 1, 0, 2, 0, 0); step(); step();
        set_in(1, 0, 0, 0, 7, 1, 0, 0, 0); step();
        idle(3);

        // PC register reads and unused operands never stall; self-dependency uses older slots only.
        set_in(1, 1, 0, 15, 0, 0, 0, 0, 0); step();
        set_in(1, 1, 0, 6, 15, 1, 0, 0, 0); step();
        set_in(1, 1, 0, 3, 3, 1, 6, 0, 0); step();
        set_in(1, 1, 0, 3, 3, 1, 3, 1, 0); step(); step();
        idle(4);

        // Drain with three writes in flight and issue held.
        set_in(1, 1, 0, 1, 0, 0, 0, 0, 0); step();
        set_in(1, 1, 0, 2, 0, 0, 0, 0, 0); step();
        set_in(1, 1, 0, 3, 0, 0, 0, 0, 0); step();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 1); step();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step();
        idle(2);

        // Reset in the middle of a drain.
        set_in(1, 1, 0, 8, 0, 0, 0, 0, 0); step();
        set_in(1, 1, 0, 9, 0, 0, 0, 0, 1); step();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0); step();
        RST = 1'b1; step();
        RST = 1'b0; idle(4);

        // drain_req held high across DONE must not re-enter DRAIN until seen low.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 1); step(); step(); step();
        idle(2);

        // Writeback mismatch: W holds Vr4, writeback reports Vr2.
        set_in(1, 1, 0, 4, 0, 0, 0, 0, 0); step();
        idle(2);
        wb_force = 1; vif.wb_valid = 1'b1; vif.wb_wa = 4'd2;
        step();
        wb_force = 0;
        idle(4);
        RST = 1'b1; step();
        RST = 1'b0; idle(2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 3) == 0,
                   $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 30) == 0);
            if ($urandom_range(0, 400) == 0) begin
                wb_force = 1;
                vif.wb_valid = 1'($urandom_range(0, 1));
                vif.wb_wa = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 300) == 0) RST = 1'b1;
            step();
            wb_force = 0;
            RST = 1'b0;
        end

        @(negedge clk); #1;
        cmp("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
